// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operations plus a counted
// burst mode that shifts or rotates a latched mode for up to WIDTH edges.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             in,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic             out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bmode_q, bmode_d;
  logic             start_shift;
  logic [LEN_W-1:0] eff_len;

  // Returns {out, q} after applying one operation.
  function automatic logic [WIDTH:0] apply_op(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] v,
                                              input logic             sin,
                                              input logic             sout,
                                              input logic [WIDTH-1:0] pv);
    case (op)
      3'b001:  return {v[WIDTH-1], v[WIDTH-2:0], sin};
      3'b010:  return {v[0], sin, v[WIDTH-1:1]};
      3'b011:  return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      3'b100:  return {v[0], v[0], v[WIDTH-1:1]};
      3'b101:  return {sout, pv};
      3'b110:  return '0;
      default: return {sout, v};
    endcase
  endfunction

  assign start_shift = start && (mode >= 3'd1) && (mode <= 3'd4);
  assign eff_len     = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    out_d   = out_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    bmode_d = bmode_q;
    unique case (state_q)
      IDLE: begin
        // A valid burst request wins over the single-step operation.
        if (start_shift) begin
          if (eff_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
            cnt_d   = eff_len;
            bmode_d = mode;
          end
        end else if (en) begin
          {out_d, q_d} = apply_op(mode, q_q, in, out_q, par_in);
        end
      end
      BURST: begin
        {out_d, q_d} = apply_op(bmode_q, q_q, in, out_q, par_in);
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= LEN_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      bmode_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      out_q   <= out_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
    end
  end

  assign q    = q_q;
  assign out  = out_q;
  assign busy = (state_q == BURST);
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): directed scenarios plus randomized
// traffic checked against a queue-based behavioural model.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       in = 1'b0;
  logic [7:0] par_in = 8'h00;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic [7:0] q;
  logic       out, busy, done;

  int errors = 0;
  int checks = 0;

  // Model: register value, last bit out, done flag, and one queue entry
  // (the shift mode) per burst shift still owed.
  int m_q = 0;
  int m_out = 0;
  int m_done = 0;
  int bq[$];

  univ_shift_reg #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .in(in),
    .par_in(par_in), .start(start), .len(len),
    .q(q), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic do_op(input int md, input int b);
    case (md)
      1: begin m_out = (m_q >> 7) & 1; m_q = ((m_q << 1) | b) & 255; end
      2: begin m_out = m_q & 1; m_q = (m_q >> 1) | (b << 7); end
      3: begin m_out = (m_q >> 7) & 1; m_q = ((m_q << 1) | (m_q >> 7)) & 255; end
      4: begin m_out = m_q & 1; m_q = (m_q >> 1) | ((m_q & 1) << 7); end
      5: m_q = int'(par_in);
      6: begin m_q = 0; m_out = 0; end
      default: ;
    endcase
  endtask

  task automatic model_step();
    int n;
    int nd;
    int md;
    nd = 0;
    if (bq.size() > 0) begin
      md = bq.pop_front();
      do_op(md, int'(in));
      if (bq.size() == 0) nd = 1;
    end else if (start && mode >= 3'd1 && mode <= 3'd4) begin
      n = (len > 4'd8) ? 8 : int'(len);
      if (n == 0) nd = 1;
      for (int i = 0; i < n; i++) bq.push_back(int'(mode));
    end else if (en) begin
      do_op(int'(mode), int'(in));
    end
    m_done = nd;
  endtask

  task automatic model_reset();
    m_q = 0; m_out = 0; m_done = 0;
    bq.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; start = 0; mode = 3'd0; in = 0; par_in = 8'h00; len = 4'd0;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1; mode = 3'd5; par_in = v; start = 0;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 0;
    model_reset();
  endtask

  task automatic test_load_shift();
    en = 1; mode = 3'd5; par_in = 8'hA5;
    tick();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q got=%h exp=a5", q); end
    mode = 3'd1; in = 1;
    tick();
    checks++; if (q !== 8'h4B) begin errors++; $display("FAIL shl_q got=%h exp=4b", q); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL shl_out got=%b exp=1", out); end
    mode = 3'd2; in = 1;
    tick();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL shr_q got=%h exp=a5", q); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL shr_out got=%b exp=1", out); end
    idle_inputs();
  endtask

  task automatic test_rotate();
    load(8'h81);
    en = 1; mode = 3'd4;
    tick();
    checks++; if (q !== 8'hC0) begin errors++; $display("FAIL rotr_q got=%h exp=c0", q); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL rotr_out got=%b exp=1", out); end
    mode = 3'd3;
    tick();
    checks++; if (q !== 8'h81) begin errors++; $display("FAIL rotl_q got=%h exp=81", q); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL rotl_out got=%b exp=1", out); end
    idle_inputs();
  endtask

  task automatic test_hold_clear();
    load(8'h3C);
    en = 0; mode = 3'd1; in = 1;
    tick();
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL en0_hold got=%h exp=3c", q); end
    en = 1; mode = 3'd7;
    tick();
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL mode7_hold got=%h exp=3c", q); end
    mode = 3'd1; in = 0;
    tick();
    mode = 3'd6;
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL clear_q got=%h exp=00", q); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL clear_out got=%b exp=0", out); end
    idle_inputs();
  endtask

  task automatic test_burst();
    logic [7:0] exp_q [3];
    logic       exp_b [3];
    exp_q = '{8'h1E, 8'h3C, 8'h78};
    exp_b = '{1'b1, 1'b1, 1'b0};
    load(8'h0F);
    start = 1; mode = 3'd1; len = 4'd3; in = 0; en = 1;
    tick();
    start = 0; mode = 3'd0; en = 0;
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL burst_start_q got=%h exp=0f", q); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_start_busy got=%b exp=1", busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL burst_q%0d got=%h exp=%h", i, q, exp_q[i]); end
      checks++; if (busy !== exp_b[i]) begin errors++; $display("FAIL burst_busy%0d got=%b exp=%b", i, busy, exp_b[i]); end
      checks++; if (done !== (i == 2)) begin errors++; $display("FAIL burst_done%0d got=%b exp=%b", i, done, i == 2); end
    end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL burst_out got=%b exp=0", out); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL burst_done_clr got=%b exp=0", done); end
  endtask

  task automatic test_clamp_zero();
    load(8'hFF);
    start = 1; mode = 3'd1; len = 4'd12; in = 0;
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clamp_busy%0d got=%b exp=1", i, busy); end
      tick();
    end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL clamp_q got=%h exp=00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clamp_busy_end got=%b exp=0", busy); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clamp_done got=%b exp=1", done); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL clamp_out got=%b exp=1", out); end
    load(8'h5A);
    start = 1; mode = 3'd2; len = 4'd0; in = 1;
    tick();
    idle_inputs();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zlen_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zlen_done got=%b exp=1", done); end
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL zlen_q got=%h exp=5a", q); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zlen_done_clr got=%b exp=0", done); end
    // An ignored start (load mode) still performs the en operation.
    start = 1; en = 1; mode = 3'd5; par_in = 8'hC3; len = 4'd3;
    tick();
    idle_inputs();
    checks++; if (q !== 8'hC3) begin errors++; $display("FAIL ign_start_q got=%h exp=c3", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_start_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ign_start_done got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid_burst();
    load(8'h0F);
    start = 1; mode = 3'd1; len = 4'd5; in = 0;
    tick();
    idle_inputs();
    tick();
    tick();
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL mid_pre_q got=%h exp=3c", q); end
    #2 reset = 1;
    #1;
    model_reset();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_rst_q got=%h exp=00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL mid_rst_out got=%b exp=0", out); end
    #1 reset = 0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got=%b exp=0", busy); end
  endtask

  task automatic test_ignored_inputs();
    logic [7:0] exp_q [3];
    exp_q = '{8'h1F, 8'h3F, 8'h7F};
    load(8'h0F);
    start = 1; mode = 3'd1; len = 4'd3; in = 1;
    tick();
    start = 1; en = 1; mode = 3'd6; len = 4'd7; par_in = 8'hFF; in = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL ign_q%0d got=%h exp=%h", i, q, exp_q[i]); end
    end
    idle_inputs();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done got=%b exp=1", done); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_nob2 got=%b exp=0", busy); end
    checks++; if (q !== 8'h7F) begin errors++; $display("FAIL ign_q_end got=%h exp=7f", q); end
  endtask

  task automatic test_random();
    int eb;
    for (int i = 0; i < 400; i++) begin
      en     = 1'($urandom_range(0, 1));
      mode   = 3'($urandom_range(0, 7));
      in     = 1'($urandom_range(0, 1));
      par_in = 8'($urandom);
      start  = ($urandom_range(0, 3) == 0);
      len    = 4'($urandom_range(0, 15));
      tick();
      eb = (bq.size() != 0);
      checks++; if (q !== 8'(m_q)) begin errors++; $display("FAIL rnd_q%0d got=%h exp=%h", i, q, 8'(m_q)); end
      checks++; if (out !== 1'(m_out)) begin errors++; $display("FAIL rnd_out%0d got=%b exp=%b", i, out, 1'(m_out)); end
      checks++; if (busy !== 1'(eb)) begin errors++; $display("FAIL rnd_busy%0d got=%b exp=%b", i, busy, 1'(eb)); end
      checks++; if (done !== 1'(m_done)) begin errors++; $display("FAIL rnd_done%0d got=%b exp=%b", i, done, 1'(m_done)); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_rotate();
    test_hold_clear();
    test_burst();
    test_clamp_zero();
    test_reset_mid_burst();
    test_ignored_inputs();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
